// File: rtl/univ_sr_pkg.sv
// Shared types and helpers for the universal shift register.
package univ_sr_pkg;

  typedef enum logic [1:0] {
    SR_HOLD = 2'b00,
    SR_SHR  = 2'b01,
    SR_SHL  = 2'b10,
    SR_LOAD = 2'b11
  } sr_mode_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/univ_sr_counter.sv
// Shift counter: wraps after WIDTH steps and emits a one-cycle done pulse.
module univ_sr_counter
  import univ_sr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic             done_pulse
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // clear outranks step so a load on the wrapping edge suppresses the pulse
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (en) begin
      if (clear) begin
        cnt_d = '0;
      end else if (step) begin
        if (cnt_q == LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt        = cnt_q;
  assign done_pulse = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load.
// Optional UNIV_SR_ROTATE_EN adds a rotate input feeding the outgoing bit back in.
module univ_shift_reg
  import univ_sr_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
`ifdef UNIV_SR_ROTATE_EN
  input  logic             rotate,
`endif
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  sr_mode_t         mode_e;
  logic [WIDTH-1:0] q_q, q_d;
  logic             fill_r, fill_l;
  logic             shift, load;

  assign mode_e = sr_mode_t'(mode);

`ifdef UNIV_SR_ROTATE_EN
  assign fill_r = rotate ? q_q[0]       : serial_in_r;
  assign fill_l = rotate ? q_q[WIDTH-1] : serial_in_l;
`else
  assign fill_r = serial_in_r;
  assign fill_l = serial_in_l;
`endif

  always_comb begin
    q_d   = q_q;
    shift = 1'b0;
    load  = 1'b0;
    case (mode_e)
      SR_SHR: begin
        q_d   = {fill_r, q_q[WIDTH-1:1]};
        shift = 1'b1;
      end
      SR_SHL: begin
        q_d   = {q_q[WIDTH-2:0], fill_l};
        shift = 1'b1;
      end
      SR_LOAD: begin
        q_d  = par_in;
        load = 1'b1;
      end
      SR_HOLD: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  univ_sr_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clear      (load),
    .step       (shift),
    .cnt        (shift_cnt),
    .done_pulse (word_done)
  );

  assign par_out      = q_q;
  assign serial_out_r = q_q[0];
  assign serial_out_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8); expectations queued per target cycle.
module tb_univ_shift_reg;
  import univ_sr_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       sir = 1'b0;
  logic       sil = 1'b0;
  logic [7:0] par_in = 8'h00;
  logic [7:0] par_out;
  logic       serial_out_r, serial_out_l;
  logic [3:0] shift_cnt;
  logic       word_done;
`ifdef UNIV_SR_ROTATE_EN
  logic       rotate = 1'b0;
`endif

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .serial_in_r  (sir),
    .serial_in_l  (sil),
`ifdef UNIV_SR_ROTATE_EN
    .rotate       (rotate),
`endif
    .par_in       (par_in),
    .par_out      (par_out),
    .serial_out_r (serial_out_r),
    .serial_out_l (serial_out_l),
    .shift_cnt    (shift_cnt),
    .word_done    (word_done)
  );

  typedef struct {
    int         cyc;
    logic [7:0] par;
    logic [3:0] cnt;
    logic       done;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every expectation whose target cycle has arrived is compared here.
  exp_t e;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc || par_out !== e.par || serial_out_r !== e.par[0] ||
          serial_out_l !== e.par[7] || shift_cnt !== e.cnt || word_done !== e.done) begin
        errors++;
        $display("FAIL %s cyc=%0d: got par=%h sor=%b sol=%b cnt=%0d done=%b, want par=%h sor=%b sol=%b cnt=%0d done=%b",
                 e.tag, cyc, par_out, serial_out_r, serial_out_l, shift_cnt, word_done,
                 e.par, e.par[0], e.par[7], e.cnt, e.done);
      end
    end
  end

  task automatic push_exp(input int c, input logic [7:0] p, input logic [3:0] n,
                          input logic d, input string tag);
    exp_t x;
    x.cyc = c; x.par = p; x.cnt = n; x.done = d; x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic op(input logic e_i, input logic [1:0] m, input logic r, input logic l,
                    input logic [7:0] p, input logic [7:0] xpar, input logic [3:0] xcnt,
                    input logic xdone, input string tag);
    @(posedge clk);
    #1;
    en = e_i; mode = m; sir = r; sil = l; par_in = p;
    push_exp(cyc + 1, xpar, xcnt, xdone, tag);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Reset raised mid-cycle must clear outputs before the next rising edge.
  task automatic async_reset(input string tag);
    drain();
    @(posedge clk);
    #2;
    rst = 1'b1; en = 1'b0; mode = 2'b00;
    push_exp(cyc, 8'h00, 4'd0, 1'b0, tag);
    drain();
    rst = 1'b0;
  endtask

  logic [7:0] shr_tbl [8] = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
  logic [7:0] shl_tbl [8] = '{8'h01, 8'h03, 8'h06, 8'h0C, 8'h19, 8'h32, 8'h65, 8'hCB};
  logic       shl_bits[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] fill_tbl[9] = '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
  logic [7:0] shl0_tbl[7] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
`ifdef UNIV_SR_ROTATE_EN
  logic [7:0] rot_tbl [8] = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
`endif

  initial begin
    int  n;
    logic ee;
    logic [7:0] xp;

    @(posedge clk);
    #1;
    push_exp(cyc, 8'h00, 4'd0, 1'b0, "por_reset");
    drain();
    rst = 1'b0;

    op(1'b1, SR_LOAD, 1'b0, 1'b0, 8'hA5, 8'hA5, 4'd0, 1'b0, "load_a5");
    for (int i = 0; i < 8; i++)
      op(1'b1, SR_SHR, 1'b0, 1'b0, 8'h00, shr_tbl[i], 4'((i + 1) % 8), i == 7, "shr_a5");

    for (int i = 0; i < 8; i++)
      op(1'b1, SR_SHL, 1'b0, shl_bits[i], 8'h00, shl_tbl[i], 4'((i + 1) % 8), i == 7, "shl_cb");

    op(1'b1, SR_LOAD, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, "load_00");
    n = 0;
    for (int k = 0; k < 27; k++) begin
      ee = !(k >= 4 && k < 7);
      if (ee) n++;
      xp = (n >= 8) ? 8'hFF : fill_tbl[n];
      op(ee, SR_SHR, 1'b1, 1'b0, 8'h00, xp, 4'(n % 8), ee && (n % 8 == 0), "shr_en_gap");
    end

    for (int i = 0; i < 7; i++)
      op(1'b1, SR_SHL, 1'b0, 1'b0, 8'h00, shl0_tbl[i], 4'(i + 1), 1'b0, "shl_seven");
    op(1'b1, SR_LOAD, 1'b0, 1'b0, 8'h3C, 8'h3C, 4'd0, 1'b0, "load_over_wrap");
    op(1'b1, SR_HOLD, 1'b1, 1'b1, 8'hFF, 8'h3C, 4'd0, 1'b0, "hold");
    op(1'b0, SR_LOAD, 1'b0, 1'b0, 8'h55, 8'h3C, 4'd0, 1'b0, "en_low_load");

    op(1'b1, SR_SHR, 1'b0, 1'b0, 8'h00, 8'h1E, 4'd1, 1'b0, "pre_reset_shr");
    op(1'b1, SR_SHR, 1'b0, 1'b0, 8'h00, 8'h0F, 4'd2, 1'b0, "pre_reset_shr");
    op(1'b1, SR_SHR, 1'b0, 1'b0, 8'h00, 8'h07, 4'd3, 1'b0, "pre_reset_shr");
    async_reset("mid_word_reset");
    op(1'b1, SR_SHL, 1'b0, 1'b1, 8'h00, 8'h01, 4'd1, 1'b0, "post_reset_shl");

`ifdef UNIV_SR_ROTATE_EN
    op(1'b1, SR_LOAD, 1'b0, 1'b0, 8'h81, 8'h81, 4'd0, 1'b0, "load_81");
    rotate = 1'b1;
    for (int i = 0; i < 8; i++)
      op(1'b1, SR_SHR, 1'b0, 1'b0, 8'h00, rot_tbl[i], 4'((i + 1) % 8), i == 7, "rot_r");
    op(1'b1, SR_SHL, 1'b0, 1'b0, 8'h00, 8'h03, 4'd1, 1'b0, "rot_l");
`endif

    op(1'b1, SR_HOLD, 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0, "final_hold");
`ifdef UNIV_SR_ROTATE_EN
    exp_q[exp_q.size() - 1].par = 8'h03;
    exp_q[exp_q.size() - 1].cnt = 4'd1;
`else
    exp_q[exp_q.size() - 1].par = 8'h01;
    exp_q[exp_q.size() - 1].cnt = 4'd1;
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, want completion before 200000");
    $fatal(1, "timeout");
  end

endmodule
